// File: rtl/fetch_if_id_pkg.sv
// Shared fetch-stage definitions: word width, opcode/NOP encodings, FSM state type
// and small PC helpers.
package fetch_if_id_pkg;

    localparam int unsigned WORD_W = 16;

    localparam logic [3:0]        OP_HLT  = 4'hF;
    localparam logic [WORD_W-1:0] NOP_ENC = 16'h0000;

    typedef enum logic {
        FS_IDLE,
        FS_WAIT
    } fetch_state_t;

    // Instructions are halfword aligned, so sequential fetch steps by 2 and wraps.
    function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
        return pc + 16'd2;
    endfunction

endpackage

// File: rtl/fetch_if_id_skid_buf.sv
// One-entry skid buffer holding a returned instruction word and its pc+2 while
// decode is stalled.
module fetch_skid_buf
    import fetch_if_id_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              drain,
    input  logic              clear,
    input  logic [WORD_W-1:0] load_data,
    input  logic [WORD_W-1:0] load_pc2,
    output logic              valid,
    output logic [WORD_W-1:0] data,
    output logic [WORD_W-1:0] pc2
);

    logic              valid_q, valid_d;
    logic [WORD_W-1:0] data_q, data_d;
    logic [WORD_W-1:0] pc2_q, pc2_d;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        pc2_d   = pc2_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
            pc2_d   = load_pc2;
        end else if (drain) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            pc2_q   <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            pc2_q   <= pc2_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;
    assign pc2   = pc2_q;

endmodule

// File: rtl/fetch_if_id.sv
// Fetch stage and IF/ID pipeline register: owns the PC, keeps one request in flight
// to instruction memory and obeys decode's stall / flush / branch redirect.
module fetch_if_id
    import fetch_if_id_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC   = 16'h0000,
    parameter logic [WORD_W-1:0] NOP_INST   = NOP_ENC,
    parameter logic [3:0]        HLT_OPCODE = OP_HLT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              if_flush,
    input  logic              br_taken,
    input  logic [WORD_W-1:0] br_target,
    output logic              imem_req,
    output logic [WORD_W-1:0] imem_addr,
    input  logic              imem_valid,
    input  logic [WORD_W-1:0] imem_data,
    output logic [WORD_W-1:0] if_id_inst,
    output logic [WORD_W-1:0] if_id_pc_plus2,
    output logic              if_id_valid,
    output logic              halted
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
    logic              imem_req_q, imem_req_d;
    logic [WORD_W-1:0] imem_addr_q, imem_addr_d;
    logic [WORD_W-1:0] inst_q, inst_d;
    logic [WORD_W-1:0] pc_plus2_q, pc_plus2_d;
    logic              valid_q, valid_d;
    logic              halted_q, halted_d;
    logic              discard_q, discard_d;

    logic              buf_valid, buf_load, buf_drain, buf_clear;
    logic [WORD_W-1:0] buf_data, buf_pc2;

    logic              issue, ret, squash, ret_hlt;
    logic [WORD_W-1:0] ret_pc2;
    logic              br_target_lsb_unused;

    assign br_target_lsb_unused = br_target[0];

    assign issue   = (state_q == FS_IDLE) && !buf_valid && !halted_q && !br_taken;
    assign ret     = (state_q == FS_WAIT) && imem_valid;
    assign squash  = br_taken || if_flush;
    assign ret_hlt = (imem_data[WORD_W-1 -: 4] == HLT_OPCODE);
    assign ret_pc2 = pc_next(fetch_pc_q);

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (buf_load),
        .drain     (buf_drain),
        .clear     (buf_clear),
        .load_data (imem_data),
        .load_pc2  (ret_pc2),
        .valid     (buf_valid),
        .data      (buf_data),
        .pc2       (buf_pc2)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        fetch_pc_d  = fetch_pc_q;
        imem_req_d  = 1'b0;
        imem_addr_d = imem_addr_q;
        inst_d      = inst_q;
        pc_plus2_d  = pc_plus2_q;
        valid_d     = valid_q;
        halted_d    = halted_q;
        discard_d   = discard_q;
        buf_load    = 1'b0;
        buf_drain   = 1'b0;
        buf_clear   = 1'b0;

        case (state_q)
            FS_IDLE: begin
                if (issue) begin
                    state_d     = FS_WAIT;
                    imem_req_d  = 1'b1;
                    imem_addr_d = pc_q;
                    fetch_pc_d  = pc_q;
                    pc_d        = pc_next(pc_q);
                end
            end
            FS_WAIT: begin
                if (imem_valid) begin
                    state_d = FS_IDLE;
                end
            end
            default: state_d = FS_IDLE;
        endcase

        if (br_taken) begin
            pc_d     = {br_target[WORD_W-1:1], 1'b0};
            halted_d = 1'b0;
        end

        // A word returning in the squash cycle is simply dropped; one still in
        // flight is tagged so its later return is dropped instead.
        if (squash) begin
            buf_clear = 1'b1;
            if (ret) begin
                discard_d = 1'b0;
            end else if (state_q == FS_WAIT) begin
                discard_d = 1'b1;
            end
            if (!stall) begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end else if (stall) begin
            if (ret) begin
                if (discard_q) begin
                    discard_d = 1'b0;
                end else begin
                    buf_load = 1'b1;
                    if (ret_hlt) begin
                        halted_d = 1'b1;
                    end
                end
            end
        end else begin
            if (ret) begin
                discard_d = 1'b0;
            end
            if (buf_valid) begin
                buf_drain  = 1'b1;
                inst_d     = buf_data;
                pc_plus2_d = buf_pc2;
                valid_d    = 1'b1;
            end else if (ret && !discard_q) begin
                inst_d     = imem_data;
                pc_plus2_d = ret_pc2;
                valid_d    = 1'b1;
                if (ret_hlt) begin
                    halted_d = 1'b1;
                end
            end else begin
                inst_d  = NOP_INST;
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FS_IDLE;
            pc_q        <= RESET_PC;
            fetch_pc_q  <= '0;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            inst_q      <= NOP_INST;
            pc_plus2_q  <= '0;
            valid_q     <= 1'b0;
            halted_q    <= 1'b0;
            discard_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            fetch_pc_q  <= fetch_pc_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            inst_q      <= inst_d;
            pc_plus2_q  <= pc_plus2_d;
            valid_q     <= valid_d;
            halted_q    <= halted_d;
            discard_q   <= discard_d;
        end
    end

    assign imem_req       = imem_req_q;
    assign imem_addr      = imem_addr_q;
    assign if_id_inst     = inst_q;
    assign if_id_pc_plus2 = pc_plus2_q;
    assign if_id_valid    = valid_q;
    assign halted         = halted_q;

endmodule
